// File: rtl/rv32i_mc_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath/memory.
// The datapath side uses master; the sequencer uses slave.
interface rv32i_mc_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic [6:0]       op_code;
   logic             br_taken;
   logic             mem_ready;
   logic             pc_we;
   logic             pc_src;
   logic             ir_we;
   logic             reg_we;
   logic             mem_req;
   logic             mem_we;
   logic             addr_sel;
   logic             trap;
   logic [1:0]       trap_cause;
   logic [2:0]       state;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] instret_cnt;

   modport master (
      output run, op_code, br_taken, mem_ready,
      input  pc_we, pc_src, ir_we, reg_we, mem_req, mem_we, addr_sel,
      input  trap, trap_cause, state, cycle_cnt, instret_cnt
   );

   modport slave (
      input  run, op_code, br_taken, mem_ready,
      output pc_we, pc_src, ir_we, reg_we, mem_req, mem_we, addr_sel,
      output trap, trap_cause, state, cycle_cnt, instret_cnt
   );
endinterface

// File: rtl/rv32i_mc_sequencer.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB over a shared memory
// port, with memory timeout, illegal-opcode trap and cycle/instret counters.
//
// state  | meaning
// IDLE   | stopped at an instruction boundary, waiting for run
// FETCH  | instruction read on the shared port, IR loads on ready
// DECODE | opcode legality check
// EXEC   | ALU step; branches update PC and retire here
// MEM    | load/store data access; stores retire on ready
// WB     | register write-back and PC update, retire
// TRAP   | sticky fault, left only through reset
module rv32i_mc_sequencer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   rv32i_mc_sequencer_if.slave     bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_BAD    = 3'd6,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam int                WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_FETCH   = 2'd2;
   localparam logic [1:0] CAUSE_DATA    = 2'd3;

   state_t            r_state;
   logic [1:0]        r_cause;
   logic [WAIT_W-1:0] r_wait;
   logic [CNT_W-1:0]  r_cycle;
   logic [CNT_W-1:0]  r_instret;

   state_t            w_state_nxt;
   logic [1:0]        w_cause_nxt;
   logic [WAIT_W-1:0] w_wait_nxt;
   logic              w_retire;
   logic              w_timeout;
   logic              w_pc_we;
   logic              w_pc_src;
   logic              w_ir_we;
   logic              w_reg_we;
   logic              w_mem_req;
   logic              w_mem_we;
   logic              w_addr_sel;

   logic w_is_load;
   logic w_is_store;
   logic w_is_branch;
   logic w_is_jump;
   logic w_legal;

   assign w_is_load   = (bus.op_code == OP_LOAD);
   assign w_is_store  = (bus.op_code == OP_STORE);
   assign w_is_branch = (bus.op_code == OP_BRANCH);
   assign w_is_jump   = (bus.op_code == OP_JAL) || (bus.op_code == OP_JALR);
   assign w_legal     = w_is_load || w_is_store || w_is_branch || w_is_jump ||
                        (bus.op_code == OP_R)   || (bus.op_code == OP_I) ||
                        (bus.op_code == OP_LUI) || (bus.op_code == OP_AUIPC);

   assign w_timeout = (r_wait == WAIT_LAST);

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      w_wait_nxt  = '0;
      w_retire    = 1'b0;
      w_pc_we     = 1'b0;
      w_pc_src    = 1'b0;
      w_ir_we     = 1'b0;
      w_reg_we    = 1'b0;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_addr_sel  = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (bus.run) w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (bus.mem_ready) begin
               w_ir_we     = 1'b1;
               w_state_nxt = S_DECODE;
            end else if (w_timeout) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = CAUSE_FETCH;
            end else begin
               w_wait_nxt = r_wait + WAIT_W'(1);
            end
         end
         S_DECODE: begin
            if (!w_legal) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = CAUSE_ILLEGAL;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (w_is_branch) begin
               w_pc_we  = 1'b1;
               w_pc_src = bus.br_taken;
               w_retire = 1'b1;
            end else if (w_is_load || w_is_store) begin
               w_state_nxt = S_MEM;
            end else begin
               w_state_nxt = S_WB;
            end
         end
         S_MEM: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            w_mem_we   = w_is_store;
            if (bus.mem_ready) begin
               if (w_is_store) begin
                  w_pc_we  = 1'b1;
                  w_retire = 1'b1;
               end else begin
                  w_state_nxt = S_WB;
               end
            end else if (w_timeout) begin
               w_state_nxt = S_TRAP;
               w_cause_nxt = CAUSE_DATA;
            end else begin
               w_wait_nxt = r_wait + WAIT_W'(1);
            end
         end
         S_WB: begin
            w_reg_we = 1'b1;
            w_pc_we  = 1'b1;
            w_pc_src = w_is_jump;
            w_retire = 1'b1;
         end
         S_TRAP: begin
         end
         default: begin
            w_state_nxt = S_TRAP;
            w_cause_nxt = CAUSE_ILLEGAL;
         end
      endcase

      // run is only honoured at the instruction boundary
      if (w_retire) w_state_nxt = bus.run ? S_FETCH : S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cause   <= 2'd0;
         r_wait    <= '0;
         r_cycle   <= '0;
         r_instret <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cause <= w_cause_nxt;
         r_wait  <= w_wait_nxt;
         if (r_state != S_IDLE && r_state != S_TRAP) r_cycle <= r_cycle + CNT_W'(1);
         if (w_retire) r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign bus.pc_we       = w_pc_we;
   assign bus.pc_src      = w_pc_src;
   assign bus.ir_we       = w_ir_we;
   assign bus.reg_we      = w_reg_we;
   assign bus.mem_req     = w_mem_req;
   assign bus.mem_we      = w_mem_we;
   assign bus.addr_sel    = w_addr_sel;
   assign bus.trap        = (r_state == S_TRAP);
   assign bus.trap_cause  = r_cause;
   assign bus.state       = r_state;
   assign bus.cycle_cnt   = r_cycle;
   assign bus.instret_cnt = r_instret;

endmodule

// File: tb/tb_rv32i_mc_sequencer.sv
// Bench for rv32i_mc_sequencer: directed scenarios then a random instruction stream,
// each cycle compared against a per-phase reference built from the opcode class.
module tb_rv32i_mc_sequencer;

   localparam int MT = 4;
   localparam int CW = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rv32i_mc_sequencer_if #(.CNT_W(CW)) bus ();

   rv32i_mc_sequencer #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int            n_cmp = 0;
   int            n_err = 0;
   logic [CW-1:0] m_cycles  = '0;
   logic [CW-1:0] m_instret = '0;
   bit            idle_next = 1'b1;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // {pc_we, pc_src, ir_we, reg_we, mem_req, mem_we, addr_sel, trap, trap_cause}
   function automatic logic [9:0] mk(input logic pc_we, input logic pc_src, input logic ir_we,
                                     input logic reg_we, input logic mem_req, input logic mem_we,
                                     input logic addr_sel, input logic [1:0] cause);
      return {pc_we, pc_src, ir_we, reg_we, mem_req, mem_we, addr_sel, (cause != 2'd0), cause};
   endfunction

   task automatic cyc(input logic rdy, input logic br, input logic rn, input logic [2:0] st,
                      input logic [9:0] strb, input bit ret, input string tag);
      logic [12:0] o;
      logic [12:0] e;
      bus.run       = rn;
      bus.mem_ready = rdy;
      bus.br_taken  = br;
      #1;
      o = {bus.state, bus.pc_we, bus.pc_src, bus.ir_we, bus.reg_we, bus.mem_req, bus.mem_we,
           bus.addr_sel, bus.trap, bus.trap_cause};
      e = {st, strb};
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s state/strobes observed=%h expected=%h", tag, o, e);
      end
      n_cmp++;
      assert (bus.cycle_cnt === m_cycles) else begin
         n_err++;
         $error("FAIL %s cycle_cnt observed=%0d expected=%0d", tag, bus.cycle_cnt, m_cycles);
      end
      n_cmp++;
      assert (bus.instret_cnt === m_instret) else begin
         n_err++;
         $error("FAIL %s instret_cnt observed=%0d expected=%0d", tag, bus.instret_cnt, m_instret);
      end
      if (st != 3'd0 && st != 3'd7) m_cycles++;
      if (ret) m_instret++;
      @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      logic [12:0] o;
      rst_n = 1'b0;
      bus.mem_ready = rb();
      bus.run       = rb();
      #1;
      o = {bus.state, bus.pc_we, bus.pc_src, bus.ir_we, bus.reg_we, bus.mem_req, bus.mem_we,
           bus.addr_sel, bus.trap, bus.trap_cause};
      n_cmp++;
      assert (o === 13'd0) else begin
         n_err++;
         $error("FAIL %s reset outputs observed=%h expected=0", tag, o);
      end
      n_cmp++;
      assert (bus.cycle_cnt === '0 && bus.instret_cnt === '0) else begin
         n_err++;
         $error("FAIL %s reset counters observed=%0d/%0d expected=0/0", tag, bus.cycle_cnt, bus.instret_cnt);
      end
      m_cycles  = '0;
      m_instret = '0;
      @(negedge clk);
      rst_n     = 1'b1;
      idle_next = 1'b1;
   endtask

   task automatic trap_cycles(input logic [1:0] cause, input string tag);
      repeat (3) cyc(rb(), rb(), rb(), 3'd7, mk(0, 0, 0, 0, 0, 0, 0, cause), 1'b0, tag);
   endtask

   // fw/mw = number of not-ready cycles before ready; >= MT means the request times out
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic br,
                            input logic rn_end, input string tag, output bit trapped);
      bit ld, st, bra, jmp, rdy;
      ld  = (op == OP_LOAD);
      st  = (op == OP_STORE);
      bra = (op == OP_BRANCH);
      jmp = (op == OP_JAL) || (op == OP_JALR);
      trapped = 1'b1;
      if (idle_next) begin
         cyc(rb(), rb(), 1'b0, 3'd0, 10'd0, 1'b0, {tag, "_idle"});
         cyc(rb(), rb(), 1'b1, 3'd0, 10'd0, 1'b0, {tag, "_idle_go"});
      end
      idle_next = 1'b0;
      bus.op_code = 7'($urandom);
      for (int i = 0; i < MT && i <= fw; i++) begin
         rdy = (i == fw);
         cyc(rdy, rb(), rb(), 3'd1, mk(0, 0, rdy, 0, 1, 0, 0, 0), 1'b0, {tag, "_fetch"});
      end
      if (fw >= MT) begin
         trap_cycles(2'd2, {tag, "_fetch_to"});
         return;
      end
      bus.op_code = op;
      cyc(rb(), rb(), rb(), 3'd2, 10'd0, 1'b0, {tag, "_decode"});
      if (!is_legal(op)) begin
         trap_cycles(2'd1, {tag, "_illegal"});
         return;
      end
      if (bra) begin
         cyc(rb(), br, rn_end, 3'd3, mk(1, br, 0, 0, 0, 0, 0, 0), 1'b1, {tag, "_exec_br"});
         trapped = 1'b0;
         idle_next = !rn_end;
         return;
      end
      cyc(rb(), rb(), rb(), 3'd3, 10'd0, 1'b0, {tag, "_exec"});
      if (ld || st) begin
         for (int j = 0; j < MT && j <= mw; j++) begin
            rdy = (j == mw);
            cyc(rdy, rb(), (st && rdy) ? rn_end : rb(), 3'd4,
                mk(st && rdy, 0, 0, 0, 1, st, 1, 0), st && rdy, {tag, "_mem"});
         end
         if (mw >= MT) begin
            trap_cycles(2'd3, {tag, "_data_to"});
            return;
         end
         if (st) begin
            trapped = 1'b0;
            idle_next = !rn_end;
            return;
         end
      end
      cyc(rb(), rb(), rn_end, 3'd5, mk(1, jmp, 0, 1, 0, 0, 0, 0), 1'b1, {tag, "_wb"});
      trapped = 1'b0;
      idle_next = !rn_end;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         tr;
      logic [6:0] op;
      logic [6:0] legal_ops [9];
      legal_ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      bus.run       = 1'b0;
      bus.op_code   = 7'd0;
      bus.br_taken  = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      do_reset("por");

      run_instr(OP_R,      0, 0, 1'b0, 1'b1, "r_type",     tr);
      run_instr(OP_LOAD,   0, 2, 1'b0, 1'b1, "load_wait2", tr);
      run_instr(OP_BRANCH, 0, 0, 1'b1, 1'b1, "br_taken",   tr);
      run_instr(OP_BRANCH, 0, 0, 1'b0, 1'b1, "br_not",     tr);
      run_instr(OP_JAL,    1, 0, 1'b0, 1'b1, "jal",        tr);
      run_instr(OP_STORE,  0, 0, 1'b0, 1'b0, "store_stop", tr);
      repeat (3) cyc(rb(), rb(), 1'b0, 3'd0, 10'd0, 1'b0, "idle_hold");
      run_instr(OP_JALR,   0, 0, 1'b0, 1'b1, "jalr",       tr);

      run_instr(7'b1111111, 0, 0, 1'b0, 1'b1, "illegal", tr);
      do_reset("after_illegal");

      run_instr(OP_R, MT, 0, 1'b0, 1'b1, "fetch_timeout", tr);
      do_reset("after_fetch_to");
      run_instr(OP_I, MT-1, 0, 1'b0, 1'b1, "fetch_last", tr);
      run_instr(OP_STORE, 0, MT-1, 1'b0, 1'b1, "store_last", tr);
      run_instr(OP_LOAD, 0, MT, 1'b0, 1'b1, "data_timeout", tr);
      do_reset("after_data_to");

      bus.op_code = OP_R;
      cyc(1'b0, 1'b0, 1'b1, 3'd0, 10'd0, 1'b0, "mid_idle");
      cyc(1'b1, 1'b0, 1'b1, 3'd1, mk(0, 0, 1, 0, 1, 0, 0, 0), 1'b0, "mid_fetch");
      cyc(1'b0, 1'b0, 1'b1, 3'd2, 10'd0, 1'b0, "mid_decode");
      do_reset("mid_reset");

      for (int k = 0; k < 80; k++) begin
         int idx;
         idx = $urandom_range(0, 9);
         if (idx == 9) begin
            do op = 7'($urandom); while (is_legal(op));
         end else begin
            op = legal_ops[idx];
         end
         run_instr(op, $urandom_range(0, MT-1), $urandom_range(0, MT-1), rb(),
                   ($urandom_range(0, 3) != 0), "rand", tr);
         if (tr) do_reset("rand_reset");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rv32i_mc_sequencer.md
# rv32i_mc_sequencer

Multi-cycle sequencer for the RV32I core. It reuses the existing datapath and single-cycle control decode, and steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It issues the strobes for the PC register, instruction register, register file and the single shared instruction/data memory port. It also guards memory handshakes with a timeout, traps on illegal opcodes, and maintains cycle and retired-instruction counters.

## Interface
- MEM_TIMEOUT, 15: maximum number of cycles a memory request is held without `mem_ready` before trapping (≥1).
- CNT_W, 32: width of `cycle_cnt` and `instret_cnt`.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = execute instructions; sampled only at instruction boundaries.
- op_code  in  7  opcode field of the instruction register; valid from DECODE onward.
- br_taken  in  1  branch comparison result from the datapath; valid in EXEC.
- mem_ready  in  1  memory port completion for the current request.
- pc_we  out  1  PC register write enable.
- pc_src  out  1  0 = PC+4, 1 = branch/jump target.
- ir_we  out  1  instruction register write enable.
- reg_we  out  1  register file write enable.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write (store); meaningful only with `mem_req`.
- addr_sel  out  1  0 = PC address, 1 = ALU address.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  1 = illegal opcode, 2 = fetch timeout, 3 = data timeout; 0 when not trapped.
- state  out  3  current state encoding.
- cycle_cnt  out  CNT_W  count of active cycles.
- instret_cnt  out  CNT_W  count of retired instructions.

## Operation
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7; codes 6 and above other than 7 go to TRAP with cause 1.
- Outputs are Moore-decoded from the registered state, qualified by `mem_ready`, `op_code` and `br_taken` as listed; every strobe not listed for a state is 0.
- Opcode classes:
  - R: 0110011
  - I: 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - JAL: 1101111
  - JALR: 1100111
  - LUI: 0110111
  - AUIPC: 0010111
  - Any other opcode is illegal.
- IDLE: no strobes. `run`=1 → FETCH.
- FETCH: `mem_req`=1, `addr_sel`=0.
  - `mem_ready`=1 → `ir_we`=1 in the same cycle, next state DECODE.
  - Timeout → TRAP, cause 2.
- DECODE: no strobes. Illegal opcode → TRAP, cause 1; otherwise → EXEC.
- EXEC:
  - BRANCH: `pc_we`=1, `pc_src`=`br_taken`; the instruction retires.
  - LOAD/STORE → MEM.
  - All other classes → WB.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=1 for STORE.
  - On `mem_ready`, STORE: `pc_we`=1, `pc_src`=0; the instruction retires.
  - On `mem_ready`, LOAD → WB.
  - Timeout → TRAP, cause 3.
- WB: `reg_we`=1, `pc_we`=1, `pc_src`=1 for JAL/JALR and 0 otherwise; the instruction retires.
- Retire: next state is FETCH if `run`=1, else IDLE. `instret_cnt` increments by 1 on that edge.
- TRAP: `trap`=1, `trap_cause` held, no strobes; exited only by reset.
- `cycle_cnt` increments in every state except IDLE and TRAP. Both counters wrap modulo 2^CNT_W.
- Deasserting `run` mid-instruction has no effect until the retire edge; the instruction always completes.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE.
  - All strobes 0.
  - `trap`=0, `trap_cause`=0.
  - Both counters 0 and the wait counter 0.
- Minimum instruction latency from FETCH entry (zero-wait memory):
  - BRANCH: 3 cycles.
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds 1 cycle.
- Wait counter:
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in that state while `mem_ready`=0.
  - If `mem_ready`=0 while wait counter = MEM_TIMEOUT−1, next state is TRAP; the request is held for at most MEM_TIMEOUT cycles.
  - `mem_ready`=1 on that final cycle completes normally, with no trap.
- `mem_ready` is ignored when `mem_req`=0.
- `op_code` is sampled combinationally in DECODE, EXEC, MEM and WB; the surrounding logic holds the IR stable, since `ir_we` fires only in FETCH.
- Reset mid-instruction aborts it immediately: no retire and no counter update.

## Test plan
- R-type 0110011, zero-wait memory, `run`=1 → states 1,2,3,5,1; `ir_we` in cycle 1, `reg_we`+`pc_we` with `pc_src`=0 in WB; `instret_cnt`=1, `cycle_cnt`=4.
- LOAD with `mem_ready` delayed 2 cycles in MEM → `mem_req`+`addr_sel` high for 3 cycles with `mem_we`=0; `reg_we` in WB; 7 cycles total.
- BRANCH with `br_taken`=1, then again with `br_taken`=0 → `pc_we`=1 in EXEC with `pc_src`=1, then 0; no `reg_we`; each takes 3 cycles.
- Illegal `op_code`=1111111 → DECODE→TRAP, `trap`=1, `trap_cause`=1, strobes 0 and counters frozen; `rst_n` low → state=0 and all outputs 0.
- MEM_TIMEOUT=4, `mem_ready` held at 0 in FETCH → `mem_req` high for exactly 4 cycles, then TRAP with cause 2. A repeat with `mem_ready` asserted in the 4th cycle → DECODE, no trap.
- STORE with `run` dropped during EXEC → MEM issues `mem_we`=1, retires on ready, then IDLE; `instret_cnt` increments once and `cycle_cnt` stops.
